// File: rtl/vid_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Holds the standard 640x480@60 mode (negative sync polarity) and a
// helper that derives the line/frame totals from the four segment widths.
package vid_timing_pkg;

    localparam int STD_H_ACTIVE = 640;
    localparam int STD_H_FP     = 16;
    localparam int STD_H_SYNC   = 96;
    localparam int STD_H_BP     = 48;
    localparam int STD_V_ACTIVE = 480;
    localparam int STD_V_FP     = 10;
    localparam int STD_V_SYNC   = 2;
    localparam int STD_V_BP     = 33;
    localparam bit STD_H_POL    = 1'b0;
    localparam bit STD_V_POL    = 1'b0;

    // Total positions in one line or one frame: active + front porch + sync + back porch.
    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Smallest width able to hold value v (used for range sanity checks).
    function automatic int bits_for(input int v);
        int n;
        n = 1;
        while ((v >> n) != 0) n++;
        return n;
    endfunction

endpackage

// File: rtl/vid_delay.sv
// Parameterised WIDTH x DEPTH shift register used to align sideband
// signals with a fixed-latency data pipeline.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset; every stage loads RESET_VAL
//   d     - input word, captured every cycle
//   q     - d delayed by DEPTH cycles (driven straight from the last stage)
module vid_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("vid_delay: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= RESET_VAL;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/vid_timing_gen.sv
// Raster timing generator for the TMDS output stage.
// Stage 0 gives the pixel pipeline early coordinates and strobes; the
// de/hsync/vsync outputs are the same decode delayed LAT cycles so they
// meet r/g/b coming out of that pipeline.
// Ports:
//   clk_pix     - pixel clock
//   rst_n       - asynchronous active-low reset
//   x, y        - early pixel / line position
//   fetch       - early active-video flag
//   line_start  - pulse at x==0
//   frame_start - pulse at x==0 && y==0
//   vblank      - early flag, y >= V_ACTIVE
//   de          - fetch delayed LAT cycles
//   hsync       - horizontal sync delayed LAT cycles, active level H_POL
//   vsync       - vertical sync delayed LAT cycles, active level V_POL
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE = STD_H_ACTIVE,
    parameter int H_FP     = STD_H_FP,
    parameter int H_SYNC   = STD_H_SYNC,
    parameter int H_BP     = STD_H_BP,
    parameter int V_ACTIVE = STD_V_ACTIVE,
    parameter int V_FP     = STD_V_FP,
    parameter int V_SYNC   = STD_V_SYNC,
    parameter int V_BP     = STD_V_BP,
    parameter bit H_POL    = STD_H_POL,
    parameter bit V_POL    = STD_V_POL,
    parameter int LAT      = 2,
    parameter int CW       = 11
) (
    input  logic          clk_pix,
    input  logic          rst_n,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          fetch,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank,
    output logic          de,
    output logic          hsync,
    output logic          vsync
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (LAT < 1 || LAT > 8) begin : g_bad_lat
        $error("vid_timing_gen: LAT must be in 1..8");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
        $error("vid_timing_gen: H_SYNC and V_SYNC must be at least 1");
    end
    if (bits_for(H_TOTAL - 1) > CW || bits_for(V_TOTAL - 1) > CW) begin : g_bad_cw
        $error("vid_timing_gen: CW too narrow for the totals");
    end

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    // Counters idle at the last position of the frame so the first edge
    // after reset lands on (0,0) and every restart is a clean frame start.
    logic [CW-1:0] hc, vc;
    logic [CW-1:0] hc_nxt, vc_nxt;
    logic          hs0, vs0;

    always_comb begin
        hc_nxt = hc + CW'(1);
        vc_nxt = vc;
        if (hc == H_LAST) begin
            hc_nxt = '0;
            vc_nxt = (vc == V_LAST) ? '0 : vc + CW'(1);
        end
    end

    // Stage 0 decodes the next position, so all early outputs describe the
    // same pixel as the counters after this edge.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            hc          <= H_LAST;
            vc          <= V_LAST;
            x           <= '0;
            y           <= '0;
            fetch       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
            hs0         <= !H_POL;
            vs0         <= !V_POL;
        end else begin
            hc          <= hc_nxt;
            vc          <= vc_nxt;
            x           <= hc_nxt;
            y           <= vc_nxt;
            fetch       <= (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
            line_start  <= (hc_nxt == '0);
            frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
            vblank      <= (vc_nxt >= V_ACT);
            hs0         <= ((hc_nxt >= HS_START) && (hc_nxt < HS_END)) ? H_POL : !H_POL;
            // Whole-line vsync: edges follow the line counter, so they fall on x==0.
            vs0         <= ((vc_nxt >= VS_START) && (vc_nxt < VS_END)) ? V_POL : !V_POL;
        end
    end

    logic [2:0] dly_q;

    vid_delay #(
        .WIDTH     (3),
        .DEPTH     (LAT),
        .RESET_VAL ({1'b0, !H_POL, !V_POL})
    ) u_delay (
        .clk   (clk_pix),
        .rst_n (rst_n),
        .d     ({fetch, hs0, vs0}),
        .q     (dly_q)
    );

    assign {de, hsync, vsync} = dly_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: small 8x6 raster, two builds (LAT=2 active-low,
// LAT=5 active-high) sharing clock and reset. Expected values come from a
// position model: edge k after reset release sits at raster index k-1.
module tb_vid_timing_gen;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = 8;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = 6;
    localparam int CW = 4;

    logic clk_pix = 1'b0;
    logic rst_n   = 1'b0;

    logic [CW-1:0] x_a, y_a, x_b, y_b;
    logic fetch_a, ls_a, fs_a, vb_a, de_a, hs_a, vs_a;
    logic fetch_b, ls_b, fs_b, vb_b, de_b, hs_b, vs_b;

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;

    always #5 clk_pix = ~clk_pix;

    vid_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b0), .V_POL(1'b0), .LAT(2), .CW(CW)
    ) dut_a (
        .clk_pix(clk_pix), .rst_n(rst_n), .x(x_a), .y(y_a), .fetch(fetch_a),
        .line_start(ls_a), .frame_start(fs_a), .vblank(vb_a),
        .de(de_a), .hsync(hs_a), .vsync(vs_a)
    );

    vid_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(1'b1), .V_POL(1'b1), .LAT(5), .CW(CW)
    ) dut_b (
        .clk_pix(clk_pix), .rst_n(rst_n), .x(x_b), .y(y_b), .fetch(fetch_b),
        .line_start(ls_b), .frame_start(fs_b), .vblank(vb_b),
        .de(de_b), .hsync(hs_b), .vsync(vs_b)
    );

    // Early outputs after edge kk: {x, y, fetch, line_start, frame_start, vblank}.
    function automatic logic [11:0] exp_s0(input int kk);
        int p, xx, yy;
        if (kk == 0) return '0;
        p  = (kk - 1) % (HT * VT);
        xx = p % HT;
        yy = p / HT;
        return {4'(xx), 4'(yy), (xx < HA) && (yy < VA), xx == 0, p == 0, yy >= VA};
    endfunction

    // Delayed outputs after edge kk: {de, hsync, vsync} reflect position at edge kk-lat.
    function automatic logic [2:0] exp_dly(input int kk, input int lat, input bit hp, input bit vp);
        int p, xx, yy;
        logic d, h, v;
        if (kk <= lat) return {1'b0, !hp, !vp};
        p  = (kk - lat - 1) % (HT * VT);
        xx = p % HT;
        yy = p / HT;
        d  = (xx < HA) && (yy < VA);
        h  = (xx >= HA + HF && xx < HA + HF + HS) ? hp : !hp;
        v  = (yy >= VA + VF && yy < VA + VF + VS) ? vp : !vp;
        return {d, h, v};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s k=%0d: got %0h expected %0h", tag, k, got, exp);
    endtask

    task automatic check_all();
        check_eq("a_early", 32'({x_a, y_a, fetch_a, ls_a, fs_a, vb_a}), 32'(exp_s0(k)));
        check_eq("a_delayed", 32'({de_a, hs_a, vs_a}), 32'(exp_dly(k, 2, 1'b0, 1'b0)));
        check_eq("b_early", 32'({x_b, y_b, fetch_b, ls_b, fs_b, vb_b}), 32'(exp_s0(k)));
        check_eq("b_delayed", 32'({de_b, hs_b, vs_b}), 32'(exp_dly(k, 5, 1'b1, 1'b1)));
    endtask

    task automatic run_edges(input int n);
        repeat (n) begin
            @(posedge clk_pix);
            k++;
            @(negedge clk_pix);
            check_all();
        end
    endtask

    initial begin
        int n;
        k = 0;
        repeat (3) begin
            @(negedge clk_pix);
            check_all();
        end
        for (int r = 0; r < 8; r++) begin
            @(negedge clk_pix);
            rst_n = 1'b1;
            k = 0;
            // Run 0 covers three full frames; run 1 stops at x=2,y=1 before
            // the mid-line reset; the rest use random lengths.
            if (r == 0)      n = 3 * HT * VT + 5;
            else if (r == 1) n = 11;
            else             n = $urandom_range(3, 120);
            run_edges(n);
            // Asynchronous reset between edges must clear outputs at once.
            #2 rst_n = 1'b0;
            #1 k = 0;
            check_all();
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk_pix);
                check_all();
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the HDMI/TMDS output stage. Drives its de, hsync and vsync inputs from the pixel clock domain.
- Also gives the pixel-generation pipeline (VDP renderer / line buffer readout) early pixel coordinates and a fetch strobe.
- de/hsync/vsync are delayed by LAT cycles so they line up with r/g/b arriving from that pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level (0 = active-low)
- LAT, 2, pixel-pipeline latency in clk_pix cycles between fetch and de; legal range 1..8
- CW, 11, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_pix, input, 1, pixel clock
- rst_n, input, 1, asynchronous active-low reset
- x, output, CW, early horizontal position of current pixel
- y, output, CW, early vertical position of current line
- fetch, output, 1, early active-video flag (x<H_ACTIVE && y<V_ACTIVE)
- line_start, output, 1, one-cycle pulse when x==0
- frame_start, output, 1, one-cycle pulse when x==0 && y==0
- vblank, output, 1, early flag y>=V_ACTIVE
- de, output, 1, fetch delayed LAT cycles; to TMDS stage
- hsync, output, 1, horizontal sync delayed LAT cycles, polarity H_POL
- vsync, output, 1, vertical sync delayed LAT cycles, polarity V_POL

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters hc, vc:
  - Reset value: hc=H_TOTAL-1, vc=V_TOTAL-1, i.e. the last position of a frame.
  - hc increments every cycle; at H_TOTAL-1 it wraps to 0 and vc increments.
  - vc wraps V_TOTAL-1 -> 0.
- Stage 0 (x, y, fetch, line_start, frame_start, vblank, internal hs0/vs0):
  - Registered decode of the next counter position; all stage-0 outputs are mutually coherent.
  - Reset values: x=0, y=0, fetch=0, line_start=0, frame_start=0, vblank=0.
  - First rising edge after rst_n deasserts: x=0, y=0, fetch=1, line_start=1, frame_start=1.
- hs0 is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vs0 is active for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines. vsync edges therefore coincide with x==0 (DVI simple mode).
- de/hsync/vsync are stage-0 fetch/hs0/vs0 passed through a LAT-deep register delay line.
  - Reset values: de=0, hsync=~H_POL, vsync=~V_POL. Delay-line contents also reset to these inactive values.
  - No glitch or stray active level appears during the first LAT cycles after reset.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-frame: rst_n low immediately (asynchronously) forces all outputs and delay-line contents to reset values. Restart is always at frame start, exactly as after power-up.
- Degenerate parameters (any porch/sync = 0) are not required to work; H_SYNC>=1 and V_SYNC>=1 are mandatory. LAT outside 1..8 is a elaboration error.

Decomposition:
- Shared package vid_timing_pkg:
  - Standard mode constants (640x480@60: H 640/16/96/48, V 480/10/2/33, both negative polarity).
  - Derived-total helper functions.
- One sub-module: vid_delay, a parameterised WIDTH x DEPTH shift register with async active-low reset to a parameterised RESET_VAL. Used here for {de, hsync, vsync}; reusable to align other sideband signals.

Test Plan:
Bench parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), LAT=2, active-low syncs, CW=4.
1. Release reset -> edge 1: x=0, y=0, fetch=1, line_start=1, frame_start=1. fetch stays high edges 1-4 and is low edges 5-8. de high edges 3-6. hsync=1 throughout reset and the first two cycles.
2. Steady run -> hsync low exactly 2 cycles per line, starting LAT=2 cycles after x==5. line_start period 8. frame_start period 48. vblank high for y=3,4,5.
3. Vertical sync -> vsync low for all 8 cycles of line y=4 (delayed by 2). vsync falling edge is coincident with delayed x==0. fetch never high while vblank=1.
4. Assert rst_n mid-line at x=2, y=1 -> same cycle: de=0, hsync=1, vsync=1, fetch=0. After release, the sequence exactly matches scenario 1.
5. Rebuild with H_POL=1, V_POL=1, LAT=5 -> reset levels hsync=0, vsync=0. Pulses active-high. de trails fetch by exactly 5 cycles.
6. Run 3 full frames at 640x480@60 defaults -> 800x525 totals, 307200 de-high cycles per frame, hsync width 96, vsync width 1600 cycles.
